// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM states and lane helpers shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  function automatic logic ldst_ok(input logic [2:0] size, input logic [1:0] a);
    return (size == LDST_B || size == LDST_BU) ? 1'b1 :
           (size == LDST_H || size == LDST_HU) ? !a[0] :
           (size == LDST_W) ? (a == 2'b00) : 1'b0;
  endfunction
  function automatic logic [3:0] ldst_be(input logic [2:0] size, input logic [1:0] a);
    return size == LDST_W ? 4'b1111 : size[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
  endfunction
  function automatic logic [31:0] ldst_wdata(input logic [2:0] size, input logic [31:0] d);
    return size == LDST_W ? d : size[0] ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
endpackage

// File: rtl/lsu_rdata_ext.sv
// lsu_rdata_ext: picks the addressed byte/half of a read word and sign/zero-extends it
//   size  : latched size code
//   a     : latched addr[1:0]
//   rdata : memory read word
//   ext   : extended load result
module lsu_rdata_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        fill;
  always_comb begin
    b    = a[1] ? (a[0] ? rdata[31:24] : rdata[23:16]) : (a[0] ? rdata[15:8] : rdata[7:0]);
    h    = a[1] ? rdata[31:16] : rdata[15:0];
    // size[2] marks the unsigned variants, size[0] the halfword ones
    fill = !size[2] && (size[0] ? h[15] : b[7]);
    ext  = size == LDST_W ? rdata : size[0] ? {{16{fill}}, h} : {{24{fill}}, b};
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit issuing one word-aligned memory access per core request
//   clk_i, reset             : clock, synchronous active-high reset
//   lsu_req_i .. lsu_data_i  : core request (we, size, byte address, store data)
//   lsu_data_o               : registered load result
//   lsu_stall_req_o          : core stall while an access is in flight
//   lsu_err_o                : one-cycle pulse for misaligned/illegal-size requests
//   data_*                   : synchronous data memory port
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 3
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sz_q;
  logic [1:0]       a_q;
  logic             ok;
  logic             accept;
  logic [31:0]      ext_data;
  lsu_rdata_ext u_ext (
    .size  (sz_q),
    .a     (a_q),
    .rdata (data_rdata_i),
    .ext   (ext_data)
  );
  always_comb begin
    ok              = ldst_ok(lsu_size_i, lsu_addr_i[1:0]);
    accept          = state == IDLE && lsu_req_i && ok;
    data_req_o      = accept;
    lsu_stall_req_o = accept || state == WAIT;
    data_we_o       = accept && lsu_we_i;
    data_be_o       = accept ? ldst_be(lsu_size_i, lsu_addr_i[1:0]) : 4'b0000;
    data_addr_o     = accept ? {lsu_addr_i[31:2], 2'b00} : 32'd0;
    data_wdata_o    = accept ? ldst_wdata(lsu_size_i, lsu_data_i) : 32'd0;
  end
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sz_q       <= LDST_W;
      a_q        <= 2'b00;
      lsu_data_o <= 32'd0;
      lsu_err_o  <= 1'b0;
    end else begin
      lsu_err_o <= state == IDLE && lsu_req_i && !ok;
      case (state)
        IDLE: if (accept) begin
          sz_q  <= lsu_size_i;
          a_q   <= lsu_addr_i[1:0];
          cnt   <= CNT_W'(MEM_LATENCY);
          state <= lsu_we_i ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            lsu_data_o <= ext_data;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed load/store sequences checked against a transaction-level model every cycle
module tb_lsu;
  localparam int LAT = 3;
  logic        clk = 0;
  logic        reset = 1;
  logic        req = 0;
  logic        we = 0;
  logic [2:0]  size = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdat = 0;
  logic [31:0] lsu_data_o;
  logic        stall;
  logic        err;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  int n_chk = 0;
  int n_fail = 0;
  lsu #(.MEM_LATENCY(LAT), .CNT_W(3)) dut (
    .clk_i           (clk),
    .reset           (reset),
    .lsu_req_i       (req),
    .lsu_we_i        (we),
    .lsu_size_i      (size),
    .lsu_addr_i      (addr),
    .lsu_data_i      (wdat),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (stall),
    .lsu_err_o       (err),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_rdata_i    (data_rdata_i)
  );
  always #5 clk = ~clk;

  // memory: byte-enable writes, reads return exactly LAT cycles after the request
  logic [31:0] mem [16] = '{default: 32'd0};
  logic [LAT-1:0] rv;
  logic [31:0] rd [LAT];
  assign data_rdata_i = rv[LAT-1] ? rd[LAT-1] : 32'hDEADBEEF;
  always @(posedge clk) begin
    if (reset) rv <= '0;
    else begin
      rv <= {rv[LAT-2:0], data_req_o & ~data_we_o};
      rd[0] <= mem[data_addr_o[5:2]];
      for (int i = 1; i < LAT; i++) rd[i] <= rd[i-1];
      if (data_req_o && data_we_o)
        for (int i = 0; i < 4; i++)
          if (data_be_o[i]) mem[data_addr_o[5:2]][8*i +: 8] <= data_wdata_o[8*i +: 8];
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic m_legal(input logic [2:0] s, input logic [1:0] a);
    case (s)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return a % 2 == 0;
      3'd2:       return a == 0;
      default:    return 1'b0;
    endcase
  endfunction
  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [1:0] a);
    if (s == 3'd2) return 4'hF;
    if (s == 3'd1 || s == 3'd5) return a >= 2 ? 4'hC : 4'h3;
    return 4'(1 << a);
  endfunction
  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
    if (s == 3'd2) return d;
    if (s == 3'd1 || s == 3'd5) return (d & 32'hFFFF) * 32'h10001;
    return (d & 32'hFF) * 32'h01010101;
  endfunction
  function automatic logic [31:0] m_ext(input logic [2:0] s, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (s == 3'd2) return w;
    if (s == 3'd1 || s == 3'd5) begin
      v = (w >> (16 * (a / 2))) & 32'hFFFF;
      return (s == 3'd1 && v >= 32'h8000) ? v - 32'h10000 : v;
    end
    v = (w >> (8 * a)) & 32'hFF;
    return (s == 3'd0 && v >= 32'h80) ? v - 32'h100 : v;
  endfunction

  // model: remaining stall cycles of the in-flight load, a "just finished" cycle, pending result
  bit          started = 0;
  int          m_left = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [31:0] m_data = 0;
  logic [31:0] m_pend = 0;
  always @(negedge clk) begin
    bit acc;
    acc = m_left == 0 && !m_done && req && m_legal(size, addr[1:0]);
    if (started) begin
      chk("data_req", 32'(data_req_o), 32'(acc));
      chk("stall", 32'(stall), 32'(acc || m_left > 0));
      chk("data_we", 32'(data_we_o), 32'(acc && we));
      chk("data_be", 32'(data_be_o), acc ? 32'(m_be(size, addr[1:0])) : 32'd0);
      chk("data_addr", data_addr_o, acc ? addr & 32'hFFFFFFFC : 32'd0);
      chk("data_wdata", data_wdata_o, acc ? m_wd(size, wdat) : 32'd0);
      chk("err", 32'(err), 32'(m_err));
      chk("lsu_data", lsu_data_o, m_data);
    end
    if (reset) begin
      started = 1; m_left = 0; m_done = 0; m_err = 0; m_data = 0;
    end else if (started) begin
      m_err = m_left == 0 && !m_done && req && !m_legal(size, addr[1:0]);
      if (acc) begin
        m_done = we;
        m_left = we ? 0 : LAT;
        m_pend = m_ext(size, addr[1:0], mem[addr[5:2]]);
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_data = m_pend; m_done = 1; end
      end else m_done = 0;
    end
  end

  int          st, nr;
  logic [3:0]  be1;
  logic [31:0] wd1;
  // issue one request and hold it until the cycle stall is low (returns at that cycle's negedge)
  task automatic op(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d,
                    output int stalls, output int nreq, output logic [3:0] be, output logic [31:0] wd);
    @(posedge clk); #1;
    req = 1; we = w; size = s; addr = a; wdat = d;
    stalls = 0; nreq = 0;
    @(negedge clk);
    be = data_be_o; wd = data_wdata_o;
    while (stall && stalls < 20) begin
      stalls++; nreq += 32'(data_req_o);
      @(negedge clk);
    end
    nreq += 32'(data_req_o);
    if (stalls >= 20) chk("stall_timeout", 32'(stalls), 32'd19);
  endtask
  task automatic idle();
    @(posedge clk); #1;
    req = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_data", lsu_data_o, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req", 32'(data_req_o), 0);
    op(1, 3'd0, 32'h10008003, 32'h000000A5, st, nr, be1, wd1);
    chk("sb_be", 32'(be1), 32'h8);
    chk("sb_wdata", wd1, 32'hA5A5A5A5);
    chk("sb_stalls", 32'(st), 1);
    op(0, 3'd0, 32'h10008003, 0, st, nr, be1, wd1);
    chk("lb_data", lsu_data_o, 32'hFFFFFFA5);
    chk("lb_stalls", 32'(st), 32'(LAT + 1));
    op(0, 3'd4, 32'h10008003, 0, st, nr, be1, wd1);
    chk("lbu_data", lsu_data_o, 32'h000000A5);
    idle();
    op(1, 3'd1, 32'h10008002, 32'hCAFE1234, st, nr, be1, wd1);
    chk("sh_be", 32'(be1), 32'hC);
    chk("sh_wdata", wd1, 32'h12341234);
    chk("sh_stalls", 32'(st), 1);
    idle();
    // back-to-back: sw then lw with only the DONE cycle between the pulses
    op(1, 3'd2, 32'h10008000, 32'h80010000, st, nr, be1, wd1);
    chk("sw_nreq", 32'(nr), 1);
    op(0, 3'd1, 32'h10008002, 0, st, nr, be1, wd1);
    chk("lh_data", lsu_data_o, 32'hFFFF8001);
    chk("lh_nreq", 32'(nr), 1);
    op(0, 3'd5, 32'h10008002, 0, st, nr, be1, wd1);
    chk("lhu_data", lsu_data_o, 32'h00008001);
    idle();
    op(0, 3'd2, 32'h10008001, 0, st, nr, be1, wd1);
    chk("mis_stalls", 32'(st), 0);
    chk("mis_nreq", 32'(nr), 0);
    idle();
    @(negedge clk); chk("mis_err_hi", 32'(err), 1);
    @(negedge clk); chk("mis_err_lo", 32'(err), 0);
    op(0, 3'd3, 32'h10008000, 0, st, nr, be1, wd1);
    chk("sz3_stalls", 32'(st), 0);
    idle();
    @(negedge clk); chk("sz3_err_hi", 32'(err), 1);
    @(negedge clk); chk("sz3_err_lo", 32'(err), 0);
    op(0, 3'd1, 32'h10008001, 0, st, nr, be1, wd1);
    idle();
    @(negedge clk); chk("h_odd_err", 32'(err), 1);
    op(0, 3'd2, 32'h10008000, 0, st, nr, be1, wd1);
    chk("lw_stalls", 32'(st), 32'(LAT + 1));
    chk("lw_nreq_held", 32'(nr), 1);
    chk("lw_data", lsu_data_o, 32'h80010000);
    idle();
    // reset in the middle of a load
    @(posedge clk); #1;
    req = 1; we = 0; size = 3'd2; addr = 32'h10008000;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1; req = 0;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_data", lsu_data_o, 0);
    chk("rstw_err", 32'(err), 0);
    op(0, 3'd2, 32'h10008000, 0, st, nr, be1, wd1);
    chk("post_rst_lw", lsu_data_o, 32'h80010000);
    chk("post_rst_stalls", 32'(st), 32'(LAT + 1));
    idle();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
